// File: rtl/adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_ctrl_mem_if
// Purpose  : Single-beat memory request / write-data / read-data port.
// Revision : 1.0  initial release
// ============================================================================
interface adder_ctrl_mem_if #(
    parameter int MEM_LEN_BITS  = 8,
    parameter int MEM_ADDR_BITS = 64,
    parameter int MEM_DATA_BITS = 64
);
    logic                     req_valid;
    logic                     req_opcode;
    logic [MEM_LEN_BITS-1:0]  req_len;
    logic [MEM_ADDR_BITS-1:0] req_addr;
    logic                     wr_valid;
    logic [MEM_DATA_BITS-1:0] wr_bits;
    logic                     rd_valid;
    logic [MEM_DATA_BITS-1:0] rd_bits;
    logic                     rd_ready;

    modport master (
        output req_valid, req_opcode, req_len, req_addr,
        output wr_valid, wr_bits, rd_ready,
        input  rd_valid, rd_bits
    );

    modport slave (
        input  req_valid, req_opcode, req_len, req_addr,
        input  wr_valid, wr_bits, rd_ready,
        output rd_valid, rd_bits
    );
endinterface
`default_nettype wire

// File: rtl/adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adder_ctrl
// Purpose  : Vector-add sequencer, c[i] = a[i] + b[i], one element at a time.
// Revision : 1.0  initial release
// ============================================================================
module adder_ctrl #(
    parameter int HOST_DATA_BITS = 32,
    parameter int MEM_LEN_BITS   = 8,
    parameter int MEM_ADDR_BITS  = 64,
    parameter int MEM_DATA_BITS  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_launch,
    output logic                      o_finish,
    output logic                      o_event_counter_valid,
    output logic [HOST_DATA_BITS-1:0] o_event_counter_value,
    input  logic [HOST_DATA_BITS-1:0] i_length,
    input  logic [HOST_DATA_BITS-1:0] i_a_addr,
    input  logic [HOST_DATA_BITS-1:0] i_b_addr,
    input  logic [HOST_DATA_BITS-1:0] i_c_addr,
    adder_ctrl_mem_if.master          mem
);

    localparam int C_STRIDE = MEM_DATA_BITS / 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_A_REQ  = 3'd1,
        ST_RD_A_WAIT = 3'd2,
        ST_RD_B_REQ  = 3'd3,
        ST_RD_B_WAIT = 3'd4,
        ST_WR_REQ    = 3'd5,
        ST_WR_DATA   = 3'd6,
        ST_FINISH    = 3'd7
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [HOST_DATA_BITS-1:0] r_index;
    logic [HOST_DATA_BITS-1:0] r_count;
    logic [MEM_DATA_BITS-1:0]  r_a;
    logic [MEM_DATA_BITS-1:0]  r_b;
    logic [MEM_ADDR_BITS-1:0]  w_elem_off;
    logic                      w_last;

    // Element offset wraps modulo the memory address width.
    assign w_elem_off = MEM_ADDR_BITS'(r_index) * MEM_ADDR_BITS'(C_STRIDE);
    assign w_last     = (r_index == (i_length - HOST_DATA_BITS'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_index <= '0;
            r_count <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_launch) begin
                        r_index <= '0;
                        r_count <= '0;
                    end
                end
                ST_RD_A_WAIT: if (mem.rd_valid) r_a <= mem.rd_bits;
                ST_RD_B_WAIT: if (mem.rd_valid) r_b <= mem.rd_bits;
                ST_WR_DATA:   r_index <= r_index + HOST_DATA_BITS'(1);
                default: ;
            endcase
            if (r_state != ST_IDLE) begin
                r_count <= r_count + HOST_DATA_BITS'(1);
            end
        end
    end

    always_comb begin
        w_next                = r_state;
        mem.req_valid         = 1'b0;
        mem.req_opcode        = 1'b0;
        mem.req_len           = MEM_LEN_BITS'(0);
        mem.req_addr          = '0;
        mem.wr_valid          = 1'b0;
        mem.wr_bits           = '0;
        mem.rd_ready          = 1'b0;
        o_finish              = 1'b0;
        o_event_counter_valid = 1'b0;
        o_event_counter_value = '0;
        case (r_state)
            ST_IDLE: begin
                if (i_launch) begin
                    w_next = (i_length == '0) ? ST_FINISH : ST_RD_A_REQ;
                end
            end
            ST_RD_A_REQ: begin
                mem.req_valid = 1'b1;
                mem.req_addr  = MEM_ADDR_BITS'(i_a_addr) + w_elem_off;
                w_next        = ST_RD_A_WAIT;
            end
            ST_RD_A_WAIT: begin
                mem.rd_ready = 1'b1;
                if (mem.rd_valid) w_next = ST_RD_B_REQ;
            end
            ST_RD_B_REQ: begin
                mem.req_valid = 1'b1;
                mem.req_addr  = MEM_ADDR_BITS'(i_b_addr) + w_elem_off;
                w_next        = ST_RD_B_WAIT;
            end
            ST_RD_B_WAIT: begin
                mem.rd_ready = 1'b1;
                if (mem.rd_valid) w_next = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                mem.req_valid  = 1'b1;
                mem.req_opcode = 1'b1;
                mem.req_addr   = MEM_ADDR_BITS'(i_c_addr) + w_elem_off;
                w_next         = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                mem.wr_valid = 1'b1;
                mem.wr_bits  = r_a + r_b;
                w_next       = w_last ? ST_FINISH : ST_RD_A_REQ;
            end
            ST_FINISH: begin
                // The register has not yet counted the FINISH cycle itself.
                o_finish              = 1'b1;
                o_event_counter_valid = 1'b1;
                o_event_counter_value = r_count + HOST_DATA_BITS'(1);
                w_next                = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_ctrl
// Purpose  : Self-checking bench for adder_ctrl with a behavioural memory.
// Revision : 1.0  initial release
// ============================================================================
module tb_adder_ctrl;
    localparam int HB = 32;
    localparam int LB = 8;
    localparam int AB = 64;
    localparam int DB = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_launch = 1'b0;
    logic          o_finish;
    logic          o_event_counter_valid;
    logic [HB-1:0] o_event_counter_value;
    logic [HB-1:0] i_length = '0;
    logic [HB-1:0] i_a_addr = '0;
    logic [HB-1:0] i_b_addr = '0;
    logic [HB-1:0] i_c_addr = '0;

    always #5 clk = ~clk;

    adder_ctrl_mem_if #(.MEM_LEN_BITS(LB), .MEM_ADDR_BITS(AB), .MEM_DATA_BITS(DB)) mif ();

    adder_ctrl #(
        .HOST_DATA_BITS(HB), .MEM_LEN_BITS(LB), .MEM_ADDR_BITS(AB), .MEM_DATA_BITS(DB)
    ) u_dut (
        .clk                   (clk),
        .rst                   (rst),
        .i_launch              (i_launch),
        .o_finish              (o_finish),
        .o_event_counter_valid (o_event_counter_valid),
        .o_event_counter_value (o_event_counter_value),
        .i_length              (i_length),
        .i_a_addr              (i_a_addr),
        .i_b_addr              (i_b_addr),
        .i_c_addr              (i_c_addr),
        .mem                   (mif)
    );

    int          total = 0;
    int          bad   = 0;
    int          viol  = 0;
    int          cyc   = 0;
    int          req_cnt = 0;
    int          rd_cnt  = 0;
    int          fin_cnt = 0;
    int          fin_cyc = 0;
    logic [31:0] fin_val = '0;
    logic [63:0] rq_addr[$];
    logic [63:0] wq_addr[$];
    logic [63:0] wq_data[$];
    logic [63:0] ram [logic [63:0]];
    logic [63:0] last_wr = '0;
    logic [63:0] pend_addr = '0;
    bit          pend = 1'b0;
    int          wait_cnt = 0;
    int          extra_g = 0;
    bit          junk_g = 1'b0;
    logic [63:0] va [16];
    logic [63:0] vb [16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model and protocol monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            pend         = 1'b0;
            mif.rd_valid = 1'b0;
            mif.rd_bits  = '0;
        end else begin
            if (mif.req_valid) begin
                req_cnt++;
                if (mif.req_len != '0) viol++;
                if (!mif.req_opcode) begin
                    rd_cnt++;
                    rq_addr.push_back(mif.req_addr);
                end else begin
                    wq_addr.push_back(mif.req_addr);
                    last_wr = mif.req_addr;
                end
            end else if (mif.req_addr != '0 || mif.req_opcode) begin
                viol++;
            end
            if (mif.wr_valid) begin
                wq_data.push_back(mif.wr_bits);
                ram[last_wr] = mif.wr_bits;
            end else if (mif.wr_bits != '0) begin
                viol++;
            end
            if (o_finish) begin
                fin_cnt++;
                fin_cyc = cyc;
                fin_val = o_event_counter_value;
            end
            if (o_event_counter_valid !== o_finish) viol++;
            if (!o_finish && o_event_counter_value != '0) viol++;
            // The controller must be waiting exactly while a read is outstanding.
            if (mif.rd_ready !== pend) viol++;
            mif.rd_valid = 1'b0;
            mif.rd_bits  = '0;
            if (pend) begin
                if (wait_cnt == 0) begin
                    mif.rd_valid = 1'b1;
                    mif.rd_bits  = ram.exists(pend_addr) ? ram[pend_addr] : 64'h0;
                    pend         = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end else if (junk_g) begin
                mif.rd_valid = 1'($urandom_range(0, 1));
                mif.rd_bits  = {$urandom, $urandom};
            end
            if (mif.req_valid && !mif.req_opcode) begin
                pend      = 1'b1;
                wait_cnt  = extra_g;
                pend_addr = mif.req_addr;
            end
        end
    end

    function automatic logic outs_any();
        return mif.req_valid | mif.req_opcode | (|mif.req_len) | (|mif.req_addr) |
               mif.wr_valid | (|mif.wr_bits) | mif.rd_ready | o_finish |
               o_event_counter_valid | (|o_event_counter_value);
    endfunction

    task automatic setup(input int n, input logic [31:0] aa, input logic [31:0] ba,
                         input logic [31:0] ca, input int extra);
        extra_g  = extra;
        i_length = 32'(n);
        i_a_addr = aa;
        i_b_addr = ba;
        i_c_addr = ca;
        for (int i = 0; i < n; i++) begin
            ram[{32'h0, aa} + 64'(8 * i)] = va[i];
            ram[{32'h0, ba} + 64'(8 * i)] = vb[i];
        end
        rq_addr.delete();
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic wait_fin(input string tag, input int fc0);
        bit ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            #1;
            if (fin_cnt != fc0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, " finish"}, 64'(ok), 64'd1);
    endtask

    task automatic check_res(input string tag, input int n, input logic [31:0] aa,
                             input logic [31:0] ba, input logic [31:0] ca,
                             input int exp_cyc, input int start);
        check({tag, " cycles"}, 64'(fin_cyc - start), 64'(exp_cyc));
        check({tag, " counter"}, 64'(fin_val), 64'(exp_cyc));
        check({tag, " nreads"}, 64'(rq_addr.size()), 64'(2 * n));
        check({tag, " nwreqs"}, 64'(wq_addr.size()), 64'(n));
        check({tag, " nwdata"}, 64'(wq_data.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (rq_addr.size() >= 2 * i + 2) begin
                check({tag, " a_addr"}, rq_addr[2*i],   {32'h0, aa} + 64'(8 * i));
                check({tag, " b_addr"}, rq_addr[2*i+1], {32'h0, ba} + 64'(8 * i));
            end
            if (wq_addr.size() > i) check({tag, " c_addr"}, wq_addr[i], {32'h0, ca} + 64'(8 * i));
            if (wq_data.size() > i) check({tag, " c_data"}, wq_data[i], va[i] + vb[i]);
        end
    endtask

    task automatic run(input string tag, input int n, input logic [31:0] aa,
                       input logic [31:0] ba, input logic [31:0] ca,
                       input int extra, input bit hold);
        int fc0;
        int start;
        int exp_cyc;
        setup(n, aa, ba, ca, extra);
        exp_cyc  = (n == 0) ? 1 : 6 * n + 1 + 2 * n * extra;
        fc0      = fin_cnt;
        start    = cyc;
        i_launch = 1'b1;
        wait_fin(tag, fc0);
        if (!hold) i_launch = 1'b0;
        check_res(tag, n, aa, ba, ca, exp_cyc, start);
        if (hold) begin
            start = cyc + 1;
            rq_addr.delete();
            wq_addr.delete();
            wq_data.delete();
            wait_fin({tag, " rerun"}, fc0 + 1);
            i_launch = 1'b0;
            check_res({tag, " rerun"}, n, aa, ba, ca, exp_cyc, start);
        end
        repeat (3) @(negedge clk);
        #1;
        check({tag, " pulses"}, 64'(fin_cnt - fc0), hold ? 64'd2 : 64'd1);
    endtask

    initial begin
        int          fc0;
        int          rc0;
        int          rq0;
        bit          found;
        logic [31:0] aa;

        repeat (3) @(negedge clk);
        #1;
        check("reset outputs", 64'(outs_any()), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("idle outputs", 64'(outs_any()), 64'd0);

        for (int i = 0; i < 4; i++) begin
            va[i] = 64'(i + 1);
            vb[i] = 64'(10 * (i + 1));
        end
        run("T1", 4, 32'h100, 32'h200, 32'h300, 0, 1'b0);

        run("T2", 0, 32'h400, 32'h500, 32'h600, 0, 1'b0);

        va[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        vb[0] = 64'h1;
        run("T3", 1, 32'h1000, 32'h2000, 32'h3000, 0, 1'b0);

        for (int i = 0; i < 2; i++) begin
            va[i] = {$urandom, $urandom};
            vb[i] = {$urandom, $urandom};
        end
        run("T4", 2, 32'h4000, 32'h5000, 32'h6000, 5, 1'b0);

        // Reset while waiting on b of element 1 of 3.
        for (int i = 0; i < 3; i++) begin
            va[i] = {$urandom, $urandom};
            vb[i] = {$urandom, $urandom};
        end
        setup(3, 32'h7000, 32'h8000, 32'h9000, 3);
        fc0      = fin_cnt;
        rc0      = rd_cnt;
        found    = 1'b0;
        i_launch = 1'b1;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            #1;
            if (rd_cnt - rc0 == 4) begin
                found = 1'b1;
                break;
            end
        end
        check("T5 reach b1", 64'(found), 64'd1);
        @(negedge clk);
        #1;
        rst      = 1'b1;
        i_launch = 1'b0;
        @(negedge clk);
        #1;
        check("T5 outputs", 64'(outs_any()), 64'd0);
        rst = 1'b0;
        rq0 = req_cnt;
        repeat (20) @(negedge clk);
        #1;
        check("T5 no traffic", 64'(req_cnt - rq0), 64'd0);
        check("T5 no finish", 64'(fin_cnt - fc0), 64'd0);

        for (int i = 0; i < 3; i++) begin
            va[i] = {$urandom, $urandom};
            vb[i] = {$urandom, $urandom};
        end
        run("T6", 3, 32'hA000, 32'hB000, 32'hC000, 1, 1'b1);

        junk_g = 1'b1;
        for (int r = 0; r < 6; r++) begin
            int n;
            n  = int'($urandom_range(1, 6));
            aa = $urandom & 32'hFFF0_FFF8;
            for (int i = 0; i < n; i++) begin
                va[i] = {$urandom, $urandom};
                vb[i] = {$urandom, $urandom};
            end
            run("RND", n, aa, aa + 32'h0001_0000, aa + 32'h0002_0000,
                int'($urandom_range(0, 3)), 1'b0);
        end

        // Bases near 2^32 must zero-extend, not wrap at 32 bits.
        for (int i = 0; i < 4; i++) begin
            va[i] = {$urandom, $urandom};
            vb[i] = {$urandom, $urandom};
        end
        run("ADDR HI", 4, 32'hFFFF_FFF0, 32'hFFFF_0FF0, 32'hFFF0_0FF8, 0, 1'b0);

        check("protocol", 64'(viol), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
